axis_nco_sweep_ctrl: RTL and testbench
======================================

Name: axis_nco_sweep_ctrl

Overview:
- Sequencer that drives the phase-increment (step) input of the NCO feeding the MASH 1-1 / second-order DSM DAC chain.
- Steps the NCO through a linear frequency sweep: start_step to stop_step in increments of step_inc, holding each step for a programmable dwell.
- Supports single-shot or repeating sweeps, abort, and AXI-stream backpressure on the step output.
- Replaces hand-sequenced step writes in benches and system top.

Parameters:
- ACC_WIDTH, 32, width of NCO phase-increment word (ACC_INT_WIDTH + ACC_FRAC_WIDTH).
- DWELL_WIDTH, 24, width of dwell cycle counter.
- IDX_WIDTH, 16, width of step_index output.

Ports:
- aclk  in  1  system clock.
- arst  in  1  synchronous reset, active-high.
- cfg_start_step  in  ACC_WIDTH  first step value, unsigned.
- cfg_stop_step  in  ACC_WIDTH  final step value, unsigned.
- cfg_step_inc  in  ACC_WIDTH  increment per step, unsigned.
- cfg_dwell  in  DWELL_WIDTH  cycles to hold each step after handshake (0 treated as 1).
- cfg_repeat  in  1  1 = restart sweep after final step; 0 = single shot.
- start  in  1  single-cycle start request.
- abort  in  1  single-cycle abort request.
- m_axis_step_tdata  out  ACC_WIDTH  step to NCO s_axis_data_tdata.
- m_axis_step_tvalid  out  1  step valid.
- m_axis_step_tready  in  1  NCO ready.
- nco_enable  out  1  high while sweep active (busy).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on single-shot completion.
- step_index  out  IDX_WIDTH  index of currently issued step, 0-based.

Behaviour:
- Reset (arst=1 at aclk edge): state IDLE; tdata=0, tvalid=0, nco_enable=0, busy=0, done=0, step_index=0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, ISSUE, DWELL, DONE.
- IDLE: on start=1 and abort=0, latch all cfg_* into internal registers (cfg changes later are ignored until next start). cur=start_step, step_index=0, go ISSUE. start with abort in same cycle: stay IDLE.
- ISSUE: tvalid=1, tdata=cur, busy=nco_enable=1. tdata held stable while tvalid=1 and tready=0. On tready=1, load dwell counter and go DWELL.
- DWELL: hold for exactly max(cfg_dwell,1) cycles; tvalid=0; tdata keeps last value. On final dwell cycle:
  - if cur is not last: cur=next, step_index+1 (wraps modulo 2^IDX_WIDTH), go ISSUE.
  - if last and repeat=1: cur=start_step, step_index=0, go ISSUE.
  - if last and repeat=0: go DONE.
- Next/last rule: sum=cur+step_inc computed in ACC_WIDTH+1 bits. If step_inc=0, or start_step>=stop_step, the sweep has exactly one step (start_step). Otherwise, if sum>=stop_step then next=stop_step (saturate, never overshoot or wrap); cur==stop_step is last.
- DONE: one cycle; done=1, busy=nco_enable=0, tvalid=0; then IDLE.
- Step period with tready held 1: dwell+1 cycles.
- start while not IDLE: ignored.
- abort in ISSUE or DWELL: next cycle IDLE, tvalid=0, busy=0, no done pulse; tdata retains last value. abort in DONE: done still completes, then IDLE.
- Latency: start sampled at cycle 0 gives tvalid=1 at cycle 1.

Test Plan:
- Basic sweep: start=100, stop=400, inc=100, dwell=3, repeat=0, tready=1, start at cycle 0 -> tvalid at cycles 1,5,9,13 with tdata 100,200,300,400 and step_index 0..3; done=1 at cycle 17 only; busy high cycles 1-16.
- Saturation: start=100, stop=350, inc=100, dwell=2 -> issued steps 100,200,300,350; no value above 350; done after 350's dwell. Repeat with stop=2^ACC_WIDTH-1, inc near max -> no wrap, final step all-ones.
- Backpressure: basic config, tready=0 for cycles 5-8 -> tdata=200 and tvalid=1 stable cycles 5-8; handshake cycle 9; next issue (300) at cycle 13.
- Repeat and degenerate cases: repeat=1, start=10, stop=30, inc=10, dwell=1 -> sequence 10,20,30,10,20,... with step_index resetting to 0; no done. inc=0 or start>=stop -> single step, done after one dwell. dwell=0 behaves as dwell=1.
- Abort/reset: abort during DWELL of step 200 -> IDLE next cycle, busy=0, no done. start+abort same cycle in IDLE -> no activity. arst mid-ISSUE -> all outputs reset next edge. start while busy -> ignored, sequence unchanged.
- Integration: drive NCO from controller, MASH chain downstream -> NCO step input matches each handshaked tdata; NCO output frequency changes at each issue.

Source files
------------

// File: rtl/axis_nco_sweep_ctrl_if.sv
// AXI-stream carrying NCO phase-increment words from the sweep controller
// to the NCO.
interface axis_nco_sweep_ctrl_if #(
  parameter int ACC_WIDTH = 32
) ();
  logic [ACC_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer: issues NCO step words from start to stop
// in increments of step_inc, holding each one for a programmable dwell.
module axis_nco_sweep_ctrl #(
  parameter int ACC_WIDTH   = 32,
  parameter int DWELL_WIDTH = 24,
  parameter int IDX_WIDTH   = 16
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic [ACC_WIDTH-1:0]       cfg_start_step,
  input  logic [ACC_WIDTH-1:0]       cfg_stop_step,
  input  logic [ACC_WIDTH-1:0]       cfg_step_inc,
  input  logic [DWELL_WIDTH-1:0]     cfg_dwell,
  input  logic                       cfg_repeat,
  input  logic                       start,
  input  logic                       abort,
  axis_nco_sweep_ctrl_if.master      m_axis_step,
  output logic                       nco_enable,
  output logic                       busy,
  output logic                       done,
  output logic [IDX_WIDTH-1:0]       step_index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   start_q, start_d;
  logic [ACC_WIDTH-1:0]   stop_q, stop_d;
  logic [ACC_WIDTH-1:0]   inc_q, inc_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   repeat_q, repeat_d;
  logic                   single_q, single_d;
  logic [ACC_WIDTH-1:0]   cur_q, cur_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   tvalid_q, tvalid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [ACC_WIDTH:0]     sum;
  logic [ACC_WIDTH-1:0]   next_step;
  logic                   at_last;

  // The extra sum bit lets the saturation compare see a carry-out instead of
  // a wrapped value near the top of the range.
  assign sum       = {1'b0, cur_q} + {1'b0, inc_q};
  assign next_step = (sum >= {1'b0, stop_q}) ? stop_q : sum[ACC_WIDTH-1:0];
  assign at_last   = single_q || (cur_q == stop_q);

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    dwell_d  = dwell_q;
    repeat_d = repeat_q;
    single_d = single_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          start_d  = cfg_start_step;
          stop_d   = cfg_stop_step;
          inc_d    = cfg_step_inc;
          dwell_d  = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
          repeat_d = cfg_repeat;
          single_d = (cfg_step_inc == '0) || (cfg_start_step >= cfg_stop_step);
          cur_d    = cfg_start_step;
          idx_d    = '0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (m_axis_step.tready) begin
          cnt_d   = dwell_q;
          state_d = S_DWELL;
        end
      end

      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q <= DWELL_WIDTH'(1)) begin
          if (!at_last) begin
            cur_d   = next_step;
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = S_ISSUE;
          end else if (repeat_q) begin
            cur_d   = start_q;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register without extra decode on the output path.
  always_comb begin
    tvalid_d = (state_d == S_ISSUE);
    busy_d   = (state_d == S_ISSUE) || (state_d == S_DWELL);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      inc_q    <= '0;
      dwell_q  <= '0;
      repeat_q <= 1'b0;
      single_q <= 1'b0;
      cur_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      inc_q    <= inc_d;
      dwell_q  <= dwell_d;
      repeat_q <= repeat_d;
      single_q <= single_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign m_axis_step.tdata  = cur_q;
  assign m_axis_step.tvalid = tvalid_q;
  assign nco_enable         = busy_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign step_index         = idx_q;

endmodule

// File: tb/tb_axis_nco_sweep_ctrl.sv
// Bench for the NCO sweep controller: a sequence-level model checked every
// cycle, plus directed sweeps with hand-computed handshake tables.
module tb_axis_nco_sweep_ctrl;
  localparam int AW = 32;
  localparam int DW = 24;
  localparam int IW = 16;

  logic          clk;
  logic          arst;
  logic [AW-1:0] cfg_start_step, cfg_stop_step, cfg_step_inc;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_repeat;
  logic          start, abort;
  logic          nco_enable, busy, done;
  logic [IW-1:0] step_index;

  axis_nco_sweep_ctrl_if #(.ACC_WIDTH(AW)) step_if ();

  axis_nco_sweep_ctrl #(.ACC_WIDTH(AW), .DWELL_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .aclk          (clk),
    .arst          (arst),
    .cfg_start_step(cfg_start_step),
    .cfg_stop_step (cfg_stop_step),
    .cfg_step_inc  (cfg_step_inc),
    .cfg_dwell     (cfg_dwell),
    .cfg_repeat    (cfg_repeat),
    .start         (start),
    .abort         (abort),
    .m_axis_step   (step_if),
    .nco_enable    (nco_enable),
    .busy          (busy),
    .done          (done),
    .step_index    (step_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  bit check_en = 0;

  // Stimulus hooks, all in cycles relative to the sampled start pulse.
  int lo_from, lo_to, abort_at, start2_at, rst_at;
  bit rand_mode;

  // Observed handshakes and done pulses of the current sweep.
  logic [AW-1:0] hs_data[$];
  int            hs_cyc[$];
  int            done_rel;
  int            done_cnt;

  // Model: the sweep is the list of step values; position and hold counter
  // walk it in time.
  logic [AW-1:0] seq[$];
  bit            m_active = 0;
  bit            m_done = 0;
  int            m_hold = 0;
  int            m_pos = 0;
  int            m_dw = 1;
  bit            m_rep = 0;
  logic [AW-1:0] m_tdata = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h exp %0h", name, cyc - c0, got, exp);
    end
  endtask

  task automatic build_seq();
    longint v;
    seq.delete();
    seq.push_back(cfg_start_step);
    if (cfg_step_inc != 0 && cfg_start_step < cfg_stop_step) begin
      v = longint'(cfg_start_step);
      while (v < longint'(cfg_stop_step)) begin
        v = v + longint'(cfg_step_inc);
        if (v > longint'(cfg_stop_step)) v = longint'(cfg_stop_step);
        seq.push_back(AW'(v));
      end
    end
  endtask

  task automatic model_step();
    if (arst) begin
      m_active = 0; m_done = 0; m_hold = 0; m_pos = 0; m_tdata = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        build_seq();
        m_active = 1; m_hold = 0; m_pos = 0; m_tdata = seq[0];
        m_dw  = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        m_rep = cfg_repeat;
      end
    end else if (abort) begin
      m_active = 0;
    end else if (m_hold == 0) begin
      if (step_if.tready) m_hold = m_dw;
    end else begin
      m_hold--;
      if (m_hold == 0) begin
        if (m_pos + 1 < seq.size()) begin
          m_pos++;
          m_tdata = seq[m_pos];
        end else if (m_rep) begin
          m_pos = 0;
          m_tdata = seq[0];
        end else begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      chk("tvalid", step_if.tvalid, m_active && m_hold == 0);
      chk("tdata", step_if.tdata, m_tdata);
      chk("busy", busy, m_active);
      chk("nco_enable", nco_enable, m_active);
      chk("done", done, m_done);
      chk("step_index", step_index, IW'(m_pos));
    end
    if (step_if.tvalid && step_if.tready) begin
      hs_data.push_back(step_if.tdata);
      hs_cyc.push_back(cyc - c0);
    end
    if (done) begin
      done_rel = cyc - c0;
      done_cnt++;
    end
    model_step();
    if (arst) check_en = 1;
  end

  task automatic clear_hooks();
    lo_from = -1; lo_to = -2; abort_at = -1; start2_at = -1; rst_at = -1;
    rand_mode = 0;
  endtask

  task automatic apply(input int rel);
    if (rand_mode) begin
      step_if.tready = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 24) == 0);
      arst  = ($urandom_range(0, 299) == 0);
    end else begin
      step_if.tready = !(rel >= lo_from && rel <= lo_to);
      abort = (rel == abort_at);
      start = (rel == start2_at);
      arst  = (rel == rst_at);
    end
  endtask

  task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] p, input logic [AW-1:0] i,
                      input logic [DW-1:0] d, input bit r, input bit with_abort);
    @(posedge clk); #1;
    cfg_start_step = s; cfg_stop_step = p; cfg_step_inc = i;
    cfg_dwell = d; cfg_repeat = r;
    start = 1'b1; abort = with_abort; arst = 1'b0; step_if.tready = 1'b1;
    $display("sweep start=%0h stop=%0h inc=%0h dwell=%0d repeat=%0d abort=%0d",
             s, p, i, d, r, with_abort);
    @(posedge clk); #1;
    c0 = cyc;
    hs_data.delete(); hs_cyc.delete();
    done_rel = -1; done_cnt = 0;
    apply(1);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      apply(cyc + 1 - c0);
    end
  endtask

  initial begin
    logic [AW-1:0] s, p, i;
    arst = 1'b1; start = 1'b0; abort = 1'b0; step_if.tready = 1'b1;
    cfg_start_step = '0; cfg_stop_step = '0; cfg_step_inc = '0;
    cfg_dwell = '0; cfg_repeat = 1'b0;
    clear_hooks();
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", step_if.tvalid, 0);
    chk("rst_tdata", step_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_index", step_index, 0);

    // Basic sweep: handshakes every dwell+1 cycles, done at 17.
    clear_hooks();
    kick(100, 400, 100, 3, 0, 0);
    run(20);
    chk("basic_n", hs_data.size(), 4);
    for (int k = 0; k < 4 && k < hs_data.size(); k++) begin
      chk("basic_data", hs_data[k], 100 * (k + 1));
      chk("basic_cyc", hs_cyc[k], 1 + 4 * k);
    end
    chk("basic_done_cyc", done_rel, 17);
    chk("basic_done_cnt", done_cnt, 1);

    // Saturation at stop value.
    kick(100, 350, 100, 2, 0, 0);
    run(16);
    chk("sat_n", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      chk("sat_d0", hs_data[0], 100);
      chk("sat_d2", hs_data[2], 300);
      chk("sat_d3", hs_data[3], 350);
      chk("sat_c3", hs_cyc[3], 10);
    end
    chk("sat_done_cyc", done_rel, 13);

    // Top-of-range sweep must clamp to all-ones rather than wrap.
    kick(32'hFFFF_FE00, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1, 0, 0);
    run(8);
    chk("top_n", hs_data.size(), 2);
    if (hs_data.size() == 2) chk("top_last", hs_data[1], 32'hFFFF_FFFF);
    chk("top_done_cyc", done_rel, 5);

    // Backpressure on the 200 step.
    lo_from = 5; lo_to = 8;
    kick(100, 400, 100, 3, 0, 0);
    run(24);
    chk("bp_n", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      chk("bp_c1", hs_cyc[1], 9);
      chk("bp_d1", hs_data[1], 200);
      chk("bp_c2", hs_cyc[2], 13);
    end
    chk("bp_done_cyc", done_rel, 21);
    clear_hooks();

    // Repeating sweep, stopped by abort.
    abort_at = 16;
    kick(10, 30, 10, 1, 1, 0);
    run(18);
    chk("rep_n", hs_data.size(), 8);
    for (int k = 0; k < 8 && k < hs_data.size(); k++)
      chk("rep_data", hs_data[k], 10 * ((k % 3) + 1));
    chk("rep_done_cnt", done_cnt, 0);
    clear_hooks();

    // Degenerate sweeps.
    kick(500, 900, 0, 2, 0, 0);
    run(8);
    chk("inc0_n", hs_data.size(), 1);
    chk("inc0_done_cyc", done_rel, 4);
    kick(900, 500, 50, 1, 0, 0);
    run(6);
    chk("rev_n", hs_data.size(), 1);
    chk("rev_done_cyc", done_rel, 3);
    kick(10, 30, 10, 0, 0, 0);
    run(10);
    chk("dw0_n", hs_data.size(), 3);
    chk("dw0_done_cyc", done_rel, 7);

    // Abort during the dwell of 200.
    abort_at = 6;
    kick(100, 400, 100, 3, 0, 0);
    run(20);
    chk("abort_n", hs_data.size(), 2);
    chk("abort_done_cnt", done_cnt, 0);
    clear_hooks();

    // Start together with abort in IDLE.
    kick(100, 400, 100, 3, 0, 1);
    run(6);
    chk("sa_n", hs_data.size(), 0);
    chk("sa_done_cnt", done_cnt, 0);

    // Reset while a step is being offered.
    lo_from = 1; lo_to = 10; rst_at = 3;
    kick(100, 400, 100, 3, 0, 0);
    run(8);
    chk("rst_n", hs_data.size(), 0);
    chk("rst_done_cnt", done_cnt, 0);
    clear_hooks();

    // Start while busy is ignored.
    start2_at = 6;
    kick(100, 400, 100, 3, 0, 0);
    run(20);
    chk("sb_n", hs_data.size(), 4);
    if (hs_data.size() == 4) chk("sb_d3", hs_data[3], 400);
    chk("sb_done_cyc", done_rel, 17);
    clear_hooks();

    // Randomised sweeps with random backpressure, aborts, restarts and resets.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) != 3) begin
        s = $urandom_range(0, 1000);
        p = $urandom_range(0, 2000);
        i = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 400);
      end else begin
        s = $urandom;
        p = $urandom;
        i = $urandom | 32'h1000_0000;
      end
      rand_mode = 0;
      kick(s, p, i, DW'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), 0);
      rand_mode = 1;
      run(60);
    end
    clear_hooks();
    apply(0);
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
